// File: rtl/conv_engine_cu.sv
// ---------------------------------------------------------------------------
// conv_engine_cu: control FSM sequencing filter/image MACs and output writes.
// Optional stall counter via CONV_ENGINE_CU_STALL_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv_engine_cu #(
  parameter int IMG_SIZE     = 16,
  parameter int FILTER_NUM   = 4,
  parameter int FILTER_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        out_ready,
  output logic [7:0]  filter_rd_adr,
  output logic [7:0]  img_rd_adr,
  output logic        acc_clr,
  output logic        mac_en,
  output logic        out_wr_en,
  output logic [7:0]  out_adr,
  output logic        busy,
  output logic        done
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int         CHUNKS      = IMG_SIZE * IMG_SIZE / FILTER_WORDS;
  localparam logic [7:0] LAST_CHUNK  = 8'(CHUNKS - 1);
  localparam logic [7:0] LAST_FILTER = 8'(FILTER_NUM - 1);
  localparam logic [7:0] LAST_WORD   = 8'(FILTER_WORDS - 1);
  localparam logic [7:0] FW8         = 8'(FILTER_WORDS);
  localparam logic [7:0] FN8         = 8'(FILTER_NUM);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cntr_img_q, cntr_img_d;
  logic [7:0] cntr_filter_q, cntr_filter_d;
  logic [7:0] cntr_word_q, cntr_word_d;
  logic       mac_en_q, acc_clr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cntr_img_q    <= 8'd0;
      cntr_filter_q <= 8'd0;
      cntr_word_q   <= 8'd0;
      mac_en_q      <= 1'b0;
      acc_clr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cntr_img_q    <= cntr_img_d;
      cntr_filter_q <= cntr_filter_d;
      cntr_word_q   <= cntr_word_d;
      // Buffer read data arrives one cycle after the address, so the MAC strobes lag by one.
      mac_en_q      <= (state_q == S_MAC);
      acc_clr_q     <= (state_q == S_MAC) && (cntr_word_q == 8'd0);
    end
  end

  always_comb begin
    state_d       = state_q;
    cntr_img_d    = cntr_img_q;
    cntr_filter_d = cntr_filter_q;
    cntr_word_d   = cntr_word_q;
    filter_rd_adr = 8'd0;
    img_rd_adr    = 8'd0;
    out_wr_en     = 1'b0;
    out_adr       = 8'd0;
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        cntr_img_d    = 8'd0;
        cntr_filter_d = 8'd0;
        cntr_word_d   = 8'd0;
        state_d       = S_MAC;
      end
      S_MAC: begin
        filter_rd_adr = cntr_filter_q * FW8 + cntr_word_q;
        img_rd_adr    = cntr_img_q * FW8 + cntr_word_q;
        cntr_word_d   = cntr_word_q + 8'd1;
        if (cntr_word_q == LAST_WORD) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cntr_word_d = 8'd0;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        out_adr   = cntr_img_q * FN8 + cntr_filter_q;
        out_wr_en = out_ready;
        if (out_ready) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (cntr_filter_q < LAST_FILTER) begin
          cntr_filter_d = cntr_filter_q + 8'd1;
          state_d       = S_MAC;
        end else begin
          cntr_filter_d = 8'd0;
          if (cntr_img_q == LAST_CHUNK) begin
            state_d = S_DONE;
          end else begin
            cntr_img_d = cntr_img_q + 8'd1;
            state_d    = S_MAC;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        cntr_img_d = 8'd0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign mac_en  = mac_en_q;
  assign acc_clr = acc_clr_q;

`ifdef CONV_ENGINE_CU_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Value survives DONE so software can read it after the pass.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_INIT) begin
      stall_cnt_d = 16'd0;
    end else if ((state_q == S_WRITE) && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= 16'd0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_conv_engine_cu.sv
// ---------------------------------------------------------------------------
// tb_conv_engine_cu: trace-level checks of conv_engine_cu against a pass model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_conv_engine_cu;

  localparam int FN   = 4;
  localparam int FW   = 4;
  localparam int MAXT = 8192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic out_ready = 1'b0;

  logic [7:0] frd_a, ird_a, oadr_a, frd_b, ird_b, oadr_b;
  logic       clr_a, mac_a, wr_a, busy_a, done_a;
  logic       clr_b, mac_b, wr_b, busy_b, done_b;
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
  logic [15:0] stall_a, stall_b;
`endif

  conv_engine_cu #(.IMG_SIZE(16), .FILTER_NUM(FN), .FILTER_WORDS(FW)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .out_ready(out_ready),
    .filter_rd_adr(frd_a), .img_rd_adr(ird_a), .acc_clr(clr_a), .mac_en(mac_a),
    .out_wr_en(wr_a), .out_adr(oadr_a), .busy(busy_a), .done(done_a)
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  conv_engine_cu #(.IMG_SIZE(4), .FILTER_NUM(FN), .FILTER_WORDS(FW)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .out_ready(out_ready),
    .filter_rd_adr(frd_b), .img_rd_adr(ird_b), .acc_clr(clr_b), .mac_en(mac_b),
    .out_wr_en(wr_b), .out_adr(oadr_b), .busy(busy_b), .done(done_b)
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  always #5 clk = ~clk;

  // {busy, done, acc_clr, mac_en, out_wr_en, filter_rd_adr, img_rd_adr, out_adr}
  wire [28:0] pack_a = {busy_a, done_a, clr_a, mac_a, wr_a, frd_a, ird_a, oadr_a};
  wire [28:0] pack_b = {busy_b, done_b, clr_b, mac_b, wr_b, frd_b, ird_b, oadr_b};

  int checks = 0;
  int errors = 0;

  bit         rdy    [MAXT];
  bit         e_busy [MAXT];
  bit         e_done [MAXT];
  bit         e_clr  [MAXT];
  bit         e_mac  [MAXT];
  bit         e_wr   [MAXT];
  logic [7:0] e_frd  [MAXT];
  logic [7:0] e_ird  [MAXT];
  logic [7:0] e_oadr [MAXT];
  int         exp_tdone, exp_stalls, obs_tdone, obs_writes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // mode 0: always ready; 1: not ready for pass cycles 0..10; 2: random backpressure
  task automatic gen_rdy(input int mode);
    for (int t = 0; t < MAXT; t++) begin
      case (mode)
        0:       rdy[t] = 1'b1;
        1:       rdy[t] = (t >= 11);
        default: rdy[t] = (t >= 2500) ? 1'b1 : ($urandom_range(0, 2) != 0);
      endcase
    end
  endtask

  // Cycle-by-cycle expected outputs of one pass; t=0 is the first cycle after start is taken.
  task automatic build_model(input int chunks);
    int t;
    for (int i = 0; i < MAXT; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_clr[i] = 0; e_mac[i] = 0; e_wr[i] = 0;
      e_frd[i] = 8'd0; e_ird[i] = 8'd0; e_oadr[i] = 8'd0;
    end
    exp_stalls = 0;
    e_busy[0] = 1;
    t = 1;
    for (int c = 0; c < chunks; c++) begin
      for (int f = 0; f < FN; f++) begin
        for (int k = 0; k < FW; k++) begin
          e_busy[t] = 1;
          e_frd[t]  = 8'(f * FW + k);
          e_ird[t]  = 8'(c * FW + k);
          e_mac[t + 1] = 1;
          if (k == 0) e_clr[t + 1] = 1;
          t++;
        end
        e_busy[t] = 1;
        t++;
        while (!rdy[t]) begin
          e_busy[t] = 1;
          e_oadr[t] = 8'(c * FN + f);
          exp_stalls++;
          t++;
        end
        e_busy[t] = 1;
        e_oadr[t] = 8'(c * FN + f);
        e_wr[t]   = 1;
        t++;
        e_busy[t] = 1;
        t++;
      end
    end
    e_busy[t] = 1;
    e_done[t] = 1;
    exp_tdone = t;
  endtask

  task automatic run_pass(input bit sel_b, input bit hold, input int stop_at, input string tag);
    int tlast;
    int perr;
    logic [28:0] obs, expv;
    tlast = (stop_at >= 0) ? stop_at : exp_tdone + 1;
    obs_tdone = -1;
    obs_writes = 0;
    perr = 0;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    for (int t = 0; t <= tlast; t++) begin
      @(posedge clk); #1;
      out_ready = rdy[t];
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      @(negedge clk);
      obs  = sel_b ? pack_b : pack_a;
      expv = {e_busy[t], e_done[t], e_clr[t], e_mac[t], e_wr[t], e_frd[t], e_ird[t], e_oadr[t]};
      if (obs[27] && obs_tdone < 0) obs_tdone = t;
      if (obs[24]) obs_writes++;
      if (perr < 8) begin
        checks++;
        assert (obs === expv) else begin
          errors++;
          perr++;
          $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, expv);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a", 32'(pack_a), 32'd0);
    check("reset_outputs_b", 32'(pack_b), 32'd0);
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
    check("reset_stall_a", 32'(stall_a), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_no_start", 32'(busy_a), 32'd0);
    end

    // Nominal pass, always ready
    gen_rdy(0);
    build_model(64);
    run_pass(1'b0, 1'b0, -1, "trace_nominal");
    check("len_nominal", 32'(obs_tdone + 2), 32'd1795);
    check("writes_nominal", 32'(obs_writes), 32'd256);

    // Five cycles of backpressure at the first write
    gen_rdy(1);
    build_model(64);
    run_pass(1'b0, 1'b0, -1, "trace_stall5");
    check("len_stall5", 32'(obs_tdone + 2), 32'd1800);
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
    check("stall_cnt_5", 32'(stall_a), 32'd5);
`endif

    // Random backpressure
    gen_rdy(2);
    build_model(64);
    run_pass(1'b0, 1'b0, -1, "trace_random");
    check("len_random", 32'(obs_tdone + 2), 32'(exp_tdone + 2));
    check("writes_random", 32'(obs_writes), 32'd256);
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
    check("stall_cnt_random", 32'(stall_a), 32'(exp_stalls));
`endif

    // Reset asserted mid-MAC of chunk 10 (t=283 is word 2 of that chunk)
    gen_rdy(0);
    build_model(64);
    run_pass(1'b0, 1'b0, 283, "trace_pre_reset");
    #1 rst = 1'b0;
    #1;
    check("async_reset_outputs", 32'(pack_a), 32'd0);
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
    check("async_reset_stall", 32'(stall_a), 32'd0);
`endif
    @(posedge clk); #1;
    check("reset_held_outputs", 32'(pack_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", 32'(busy_a), 32'd0);
    end
    run_pass(1'b0, 1'b0, -1, "trace_after_reset");
    check("len_after_reset", 32'(obs_tdone + 2), 32'd1795);

    // Start held through the pass: exactly one pass, then a second one from IDLE
    gen_rdy(0);
    build_model(64);
    run_pass(1'b0, 1'b1, -1, "trace_hold_first");
    check("len_hold_first", 32'(obs_tdone + 2), 32'd1795);
    run_pass(1'b0, 1'b0, -1, "trace_hold_second");
    check("len_hold_second", 32'(obs_tdone + 2), 32'd1795);

    // Small image instance
    gen_rdy(0);
    build_model(4);
    run_pass(1'b1, 1'b0, -1, "trace_img4");
    check("len_img4", 32'(obs_tdone + 2), 32'd115);
    check("writes_img4", 32'(obs_writes), 32'd16);
    check("img4_other_idle", 32'(busy_a), 32'd0);

    gen_rdy(2);
    build_model(4);
    run_pass(1'b1, 1'b0, -1, "trace_img4_random");
    check("len_img4_random", 32'(obs_tdone + 2), 32'(exp_tdone + 2));
`ifdef CONV_ENGINE_CU_STALL_CNT_EN
    check("stall_cnt_img4", 32'(stall_b), 32'(exp_stalls));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
